// File: rtl/fetch_prefetch.sv
// Prefetching instruction fetch stage: pipelined Avalon-MM reads into a DEPTH-entry PC-tagged queue.
// Optional FETCH_ALIGN_CHK_EN: misaligned redirect raises fault and blocks new issues.
module fetch_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        active,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] address,
  output logic        read,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  input  logic        readdatavalid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        fault
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

  logic [31:0]   q_word [DEPTH];
  logic [31:0]   q_pc   [DEPTH];
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count, inflight, discard;
  logic [CW-1:0] count_n, inflight_n, discard_n;
  logic [CW:0]   occupancy;
  logic [31:0]   fetch_pc, resp_pc, target, next_pc;
  logic          kill_held, kill_held_n;
  logic          accept, hold, push, pop, launch, fault_n;

  assign byteenable  = '1;
  assign instr       = q_word[head];
  assign instr_pc    = q_pc[head];
  assign instr_valid = (count != '0);
  assign target      = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_ALIGN_CHK_EN
  assign fault_n = redirect ? (redirect_pc[1:0] != 2'b00) : fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault <= 1'b0;
    else        fault <= fault_n;
  end
`else
  logic align_unused;
  assign align_unused = ^redirect_pc[1:0];
  assign fault_n      = 1'b0;
  assign fault        = 1'b0;
`endif

  always_comb begin
    accept = read && !waitrequest;
    hold   = read && waitrequest;

    inflight_n = inflight;
    if (accept)        inflight_n = inflight_n + CW'(1);
    if (readdatavalid) inflight_n = inflight_n - CW'(1);

    push = readdatavalid && !redirect && (discard == '0);
    pop  = instr_valid && !stall && !redirect;

    count_n = count;
    if (redirect) begin
      count_n = '0;
    end else begin
      if (push) count_n = count_n + CW'(1);
      if (pop)  count_n = count_n - CW'(1);
    end

    // A request still held at redirect time is killed once the slave finally takes it.
    discard_n = discard;
    if (readdatavalid && (discard != '0)) discard_n = discard_n - CW'(1);
    if (accept && kill_held)              discard_n = discard_n + CW'(1);
    if (redirect)                         discard_n = inflight_n;
    kill_held_n = redirect ? hold : (accept ? 1'b0 : kill_held);

    // Issue is decided a cycle early, so gate on post-edge occupancy.
    next_pc   = redirect ? target : fetch_pc;
    occupancy = {1'b0, count_n} + {1'b0, inflight_n};
    launch    = !hold && active && !fault_n && (occupancy < DEPTH_W);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read      <= 1'b0;
      address   <= RESET_PC;
      fetch_pc  <= RESET_PC;
      resp_pc   <= RESET_PC;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      inflight  <= '0;
      discard   <= '0;
      kill_held <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_word[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else begin
      count     <= count_n;
      inflight  <= inflight_n;
      discard   <= discard_n;
      kill_held <= kill_held_n;
      if (!hold) begin
        read    <= launch;
        address <= next_pc;
      end
      fetch_pc <= launch ? next_pc + 32'd4 : next_pc;
      if (redirect)  resp_pc <= target;
      else if (push) resp_pc <= resp_pc + 32'd4;
      if (push) begin
        q_word[tail] <= readdata;
        q_pc[tail]   <= resp_pc;
        tail         <= tail + AW'(1);
      end
      if (redirect) head <= tail;
      else if (pop) head <= head + AW'(1);
    end
  end

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed self-checking bench for fetch_prefetch with an in-order variable-latency Avalon slave.
module tb_fetch_prefetch;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst_n, active, stall, redirect, waitrequest, readdatavalid;
  logic [31:0] redirect_pc, readdata;
  logic [31:0] address, instr, instr_pc;
  logic        read, instr_valid, fault;
  logic [3:0]  byteenable;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  int          lat   = 1;
  logic [31:0] exp_pc;
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  fetch_prefetch #(.DEPTH(4), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .active(active), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .address(address), .read(read), .byteenable(byteenable),
    .waitrequest(waitrequest), .readdata(readdata), .readdatavalid(readdatavalid),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5A5_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Slave: records accepts, returns data in order exactly lat cycles later.
  task automatic step();
    if (read && !waitrequest) begin
      pend_addr.push_back(address);
      pend_due.push_back(cyc + lat);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pend_due.size() > 0 && pend_due[0] == cyc) begin
      readdatavalid = 1'b1;
      readdata      = data_of(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      readdatavalid = 1'b0;
      readdata      = '0;
    end
  endtask

  task automatic consume();
    if (instr_valid && !stall && !redirect) begin
      check("q_pc", instr_pc, exp_pc);
      check("q_word", instr, data_of(exp_pc));
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic cyc_end();
    consume();
    step();
  endtask

  task automatic redir(input logic [31:0] a);
    redirect    = 1'b1;
    redirect_pc = a;
    exp_pc      = {a[31:2], 2'b00};
    cyc_end();
    redirect    = 1'b0;
  endtask

  task automatic do_reset(input int l);
    rst_n = 1'b0; active = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    waitrequest = 1'b0; readdatavalid = 1'b0; readdata = '0; lat = l;
    pend_addr.delete();
    pend_due.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_read", 32'(read), 32'd0);
    check("rst_addr", address, RST_PC);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    rst_n  = 1'b1;
    cyc    = 0;
    exp_pc = RST_PC;
  endtask

  initial begin
    // Zero-wait streaming, latency 1
    do_reset(1);
    for (int s = 1; s <= 8; s++) begin
      cyc_end();
      check("seq_addr", address, RST_PC + 32'(4 * (s - 1)));
      check("seq_read", 32'(read), 32'd1);
      if (s >= 3) check("seq_pc", instr_pc, RST_PC + 32'(4 * (s - 3)));
    end

    // Stall for cycles 8..12: issue backs off at 4 queued/in flight, head holds
    stall = 1'b1;
    for (int k = 9; k <= 13; k++) begin
      cyc_end();
      check("stall_pc", instr_pc, RST_PC + 32'h14);
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_read", 32'(read), (k == 9) ? 32'd1 : 32'd0);
    end
    stall = 1'b0;
    cyc_end();
    check("resume_read", 32'(read), 32'd1);
    check("resume_addr", address, RST_PC + 32'h24);
    repeat (10) cyc_end();

    // Waitrequest on the third request
    do_reset(1);
    repeat (3) cyc_end();
    waitrequest = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("wr_addr", address, RST_PC + 32'h8);
      check("wr_read", 32'(read), 32'd1);
      cyc_end();
    end
    waitrequest = 1'b0;
    check("wr_accept_addr", address, RST_PC + 32'h8);
    cyc_end();
    check("wr_next_addr", address, RST_PC + 32'hC);
    check("wr_next_read", 32'(read), 32'd1);
    repeat (6) cyc_end();

    // Latency 3, redirect with two reads in flight
    do_reset(3);
    cyc_end();
    cyc_end();
    active = 1'b0;
    cyc_end();
    check("inactive_read", 32'(read), 32'd0);
    active = 1'b1;
    redir(32'h0040_0000);
    check("lat3_addr", address, 32'h0040_0000);
    check("lat3_read", 32'(read), 32'd1);
    for (int k = 4; k <= 7; k++) begin
      check("lat3_flushed", 32'(instr_valid), 32'd0);
      cyc_end();
    end
    check("lat3_valid", 32'(instr_valid), 32'd1);
    check("lat3_first_pc", instr_pc, 32'h0040_0000);
    repeat (6) cyc_end();

    // Redirect coinciding with a response and a held request
    do_reset(1);
    cyc_end();
    cyc_end();
    waitrequest = 1'b1;
    redir(32'h0040_0000);
    check("held_addr", address, RST_PC + 32'h4);
    check("held_read", 32'(read), 32'd1);
    check("held_valid", 32'(instr_valid), 32'd0);
    waitrequest = 1'b0;
    cyc_end();
    check("post_held_addr", address, 32'h0040_0000);
    check("post_held_read", 32'(read), 32'd1);
    check("post_held_valid", 32'(instr_valid), 32'd0);
    cyc_end();
    check("drop_valid", 32'(instr_valid), 32'd0);
    cyc_end();
    check("redir_valid", 32'(instr_valid), 32'd1);
    check("redir_pc", instr_pc, 32'h0040_0000);
    repeat (4) cyc_end();

    // Misaligned redirect
`ifdef FETCH_ALIGN_CHK_EN
    redir(32'h0040_0002);
    check("mis_fault", 32'(fault), 32'd1);
    check("mis_read", 32'(read), 32'd0);
    repeat (3) begin
      cyc_end();
      check("mis_hold_read", 32'(read), 32'd0);
      check("mis_hold_fault", 32'(fault), 32'd1);
      check("mis_hold_valid", 32'(instr_valid), 32'd0);
    end
    redir(32'h0040_0010);
    check("clr_fault", 32'(fault), 32'd0);
    check("clr_read", 32'(read), 32'd1);
    check("clr_addr", address, 32'h0040_0010);
`else
    redir(32'h0040_0002);
    check("mis_fault", 32'(fault), 32'd0);
    check("mis_read", 32'(read), 32'd1);
    check("mis_addr", address, 32'h0040_0000);
`endif
    repeat (6) cyc_end();

    // Address wrap at the top of the space
    redir(32'hFFFF_FFF8);
    check("wrap_addr0", address, 32'hFFFF_FFF8);
    cyc_end();
    check("wrap_addr1", address, 32'hFFFF_FFFC);
    cyc_end();
    check("wrap_addr2", address, 32'h0000_0000);
    check("wrap_fault", 32'(fault), 32'd0);
    repeat (6) cyc_end();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
